// File: rtl/dm_pkg.sv
// Shared definitions for the MEM-stage data-memory sequencer.
// Holds the opcode map, FSM encoding and access-shape helpers.
package dm_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_NONE = 2'd3
    } size_t;

    function automatic size_t size_of(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: size_of = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: size_of = SZ_HALF;
            OP_LW, OP_SW:         size_of = SZ_WORD;
            default:              size_of = SZ_NONE;
        endcase
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic unsupported(input logic [5:0] op);
        return size_of(op) == SZ_NONE;
    endfunction

    function automatic logic [3:0] be_of(input logic [5:0] op, input logic [1:0] addr);
        case (size_of(op))
            SZ_BYTE: be_of = 4'b0001 << addr;
            SZ_HALF: be_of = addr[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be_of = 4'b1111;
            default: be_of = 4'b0000;
        endcase
    endfunction

    function automatic logic misaligned(input logic [5:0] op, input logic [1:0] addr);
        case (size_of(op))
            SZ_HALF: misaligned = addr[0];
            SZ_WORD: misaligned = (addr != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

    // Stores drive every lane; byte enables pick which lanes actually land.
    function automatic logic [31:0] replicate(input logic [5:0] op, input logic [31:0] wd);
        case (size_of(op))
            SZ_BYTE: replicate = {4{wd[7:0]}};
            SZ_HALF: replicate = {2{wd[15:0]}};
            default: replicate = wd;
        endcase
    endfunction

endpackage

// File: rtl/dm_load_extract.sv
// Lane select plus sign/zero extension of a DM read word for a load opcode.
module dm_load_extract
    import dm_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_word,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_addr_lo)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_data = i_word;
        case (i_op)
            OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_data = {24'h0, w_byte};
            OP_LH:   o_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_data = {16'h0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/dm_access_seq.sv
// One-at-a-time load/store sequencer between the MEM stage and a synchronous DM.
// All dm_* outputs come straight from flops so the memory sees clean strobes.
module dm_access_seq
    import dm_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [5:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic              dm_en,
    output logic              dm_we,
    output logic [3:0]        dm_be,
    output logic [ADDR_W-3:0] dm_addr,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t              r_state;
    state_t              w_next;
    logic [5:0]          r_op;
    logic [1:0]          r_addr_lo;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err;
    logic [31:0]         r_rdata;
    logic                r_dm_en;
    logic                r_dm_we;
    logic [3:0]          r_dm_be;
    logic [ADDR_W-3:0]   r_dm_addr;
    logic [31:0]         r_dm_wdata;

    logic                w_accept;
    logic                w_req_err;
    logic                w_cnt_zero;
    logic [31:0]         w_ext;
    logic                w_unused_addr;

    assign w_accept      = req_valid && (r_state == ST_IDLE);
    assign w_req_err     = unsupported(req_op) || misaligned(req_op, req_addr[1:0]);
    assign w_cnt_zero    = (r_cnt == '0);
    assign w_unused_addr = ^req_addr[31:ADDR_W];

    dm_load_extract u_extract (
        .i_op      (r_op),
        .i_addr_lo (r_addr_lo),
        .i_word    (dm_rdata),
        .o_data    (w_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = w_req_err ? ST_RESP : ST_ISSUE;
            ST_ISSUE: w_next = is_store(r_op) ? ST_RESP : ST_WAIT;
            ST_WAIT:  if (w_cnt_zero) w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // The access is registered at accept so dm_en lines up with the ISSUE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= '0;
            r_addr_lo  <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_dm_en    <= 1'b0;
            r_dm_we    <= 1'b0;
            r_dm_be    <= '0;
            r_dm_addr  <= '0;
            r_dm_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op      <= req_op;
                        r_addr_lo <= req_addr[1:0];
                        r_err     <= w_req_err;
                        r_rdata   <= '0;
                        if (!w_req_err) begin
                            r_dm_en   <= 1'b1;
                            r_dm_we   <= is_store(req_op);
                            r_dm_be   <= be_of(req_op, req_addr[1:0]);
                            r_dm_addr <= req_addr[ADDR_W-1:2];
                            if (is_store(req_op))
                                r_dm_wdata <= replicate(req_op, req_wdata);
                        end
                    end
                end
                ST_ISSUE: begin
                    r_dm_en <= 1'b0;
                    r_dm_we <= 1'b0;
                    r_cnt   <= CNT_W'(MEM_LAT - 1);
                end
                ST_WAIT: begin
                    if (!w_cnt_zero) r_cnt   <= r_cnt - 1'b1;
                    else             r_rdata <= w_ext;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_err   = rsp_valid && r_err;
    assign rsp_rdata = r_rdata;
    assign dm_en     = r_dm_en;
    assign dm_we     = r_dm_we;
    assign dm_be     = r_dm_be;
    assign dm_addr   = r_dm_addr;
    assign dm_wdata  = r_dm_wdata;

endmodule
